// File: rtl/float_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : float_pkg
//  Brief    : Shared IEEE-754 single-precision field widths, flag bit indices
//             and the classify helper used by the ALU and its result buffer.
//  Revision : 1.0  initial release
// ============================================================================
package float_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int FLAGS_W = 4;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    localparam int FLAG_NAN  = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_SUB  = 0;

    // Class flags {nan, inf, zero, subnormal}; sign is ignored for all classes.
    function automatic logic [FLAGS_W-1:0] classify(input logic [31:0] value);
        logic [EXP_W-1:0]   w_exp;
        logic [MANT_W-1:0]  w_mant;
        logic [FLAGS_W-1:0] w_flags;
        w_exp   = value[MANT_W +: EXP_W];
        w_mant  = value[MANT_W-1:0];
        w_flags = '0;
        w_flags[FLAG_NAN]  = (w_exp == EXP_ALL_ONES) && (w_mant != '0);
        w_flags[FLAG_INF]  = (w_exp == EXP_ALL_ONES) && (w_mant == '0);
        w_flags[FLAG_ZERO] = (w_exp == '0) && (w_mant == '0);
        w_flags[FLAG_SUB]  = (w_exp == '0) && (w_mant != '0);
        return w_flags;
    endfunction

endpackage : float_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock first-word-fall-through FIFO. The head entry is
//             always visible on o_data; push while full is accepted only when
//             a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/float_result_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : float_result_buffer
//  Brief    : Captures float ALU results with IEEE-754 class flags into a FWFT
//             FIFO, tracks in-flight operations to issue credits, and counts
//             results lost to overrun.
//  Revision : 1.0  initial release
// ============================================================================
module float_result_buffer
    import float_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int DROP_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue,
    input  logic [31:0]          alu_result,
    input  logic                 alu_valid,
    output logic                 can_issue,
    output logic [31:0]          out_data,
    output logic [FLAGS_W-1:0]   out_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DROP_W-1:0]    drop_count,
    output logic                 overrun
);

    localparam int                ENTRY_W = 32 + FLAGS_W;
    localparam int                IF_W    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IF_W-1:0]   IF_MAX  = IF_W'(MAX_INFLIGHT);

    logic [ENTRY_W-1:0]          w_wr_entry;
    logic [ENTRY_W-1:0]          w_rd_entry;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(DEPTH):0]      w_count;
    logic                        w_pop;
    logic                        w_drop;

    logic [IF_W-1:0]             r_inflight;
    logic [DROP_W-1:0]           r_drop_count;
    logic                        r_overrun;

    // Flags are computed once at capture and travel with the word.
    assign w_wr_entry = {classify(alu_result), alu_result};
    assign w_pop      = !w_empty && out_ready;
    assign w_drop     = alu_valid && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (alu_valid),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_valid  = !w_empty;
    assign out_data   = w_rd_entry[31:0];
    assign out_flags  = w_rd_entry[ENTRY_W-1:32];
    assign drop_count = r_drop_count;
    assign overrun    = r_overrun;

    // Credit from registered state only: room for every in-flight result plus a new one.
    assign can_issue = ((32'(w_count) + 32'(r_inflight)) < 32'(DEPTH)) &&
                       (32'(r_inflight) < 32'(MAX_INFLIGHT));

    // In-flight counter: issue adds, result return subtracts; both clamp at the limits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (issue && !alu_valid) begin
            if (r_inflight != IF_MAX) begin
                r_inflight <= r_inflight + 1'b1;
            end
        end else if (alu_valid && !issue) begin
            if (r_inflight != '0) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end
    end

    // Saturating drop counter and sticky overrun flag for results that found no room.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_count <= '0;
            r_overrun    <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

endmodule : float_result_buffer
`default_nettype wire

// File: tb/tb_float_result_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_float_result_buffer
//  Brief    : Self-checking bench for float_result_buffer with a queue-based
//             reference model, directed scenarios and a randomized phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_float_result_buffer;

    localparam int DEPTH    = 8;
    localparam int MAX_INF  = 4;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue;
    logic [31:0]       alu_result;
    logic              alu_valid;
    logic              can_issue;
    logic [31:0]       out_data;
    logic [3:0]        out_flags;
    logic              out_valid;
    logic              out_ready;
    logic [DROP_W-1:0] drop_count;
    logic              overrun;

    float_result_buffer #(
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAX_INF),
        .DROP_W       (DROP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .alu_result (alu_result),
        .alu_valid  (alu_valid),
        .can_issue  (can_issue),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   m_inflight = 0;
    int   m_drop     = 0;
    bit   m_overrun  = 1'b0;
    int   n_assert   = 0;
    int   n_fail     = 0;

    // Class of a single-precision word from its exponent and mantissa values.
    function automatic logic [3:0] ref_flags(input logic [31:0] v);
        int e;
        int m;
        e = int'((v >> 23) & 32'hFF);
        m = int'(v & 32'h007F_FFFF);
        if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_ci;
        exp_ci = ((q.size() + m_inflight) < DEPTH) && (m_inflight < MAX_INF);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_flags", 32'(out_flags), 32'(q[0].f));
        end
        chk("can_issue", 32'(can_issue), 32'(exp_ci));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("overrun", 32'(overrun), 32'(m_overrun));
    endtask

    // One clock: drive inputs, check current outputs, advance model, take the edge.
    task automatic step(input bit iss, input bit vld, input logic [31:0] d, input bit rdy);
        rst_n      = 1'b1;
        issue      = iss;
        alu_valid  = vld;
        alu_result = d;
        out_ready  = rdy;
        check_outputs();
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (vld) begin
            if (q.size() < DEPTH) begin
                q.push_back('{f: ref_flags(d), d: d});
            end else begin
                if (m_drop < DROP_MAX) m_drop++;
                m_overrun = 1'b1;
            end
        end
        if (iss && !vld && m_inflight < MAX_INF) m_inflight++;
        if (vld && !iss && m_inflight > 0)       m_inflight--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        issue      = 1'b0;
        alu_valid  = 1'b0;
        alu_result = '0;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_inflight = 0;
        m_drop     = 0;
        m_overrun  = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        bit          iss;
        bit          vld;

        do_reset();
        do_reset();

        // Three ordinary results flow through in order with clear flags.
        repeat (3) step(1, 0, 32'h0, 1);
        step(0, 1, 32'hC194_0000, 1);
        step(0, 1, 32'h4183_0000, 1);
        step(0, 1, 32'h41BE_0000, 1);
        repeat (4) step(0, 0, 32'h0, 1);

        // Special values: NaN, +inf, -0, smallest subnormal.
        step(0, 1, 32'h7FC0_0000, 1);
        step(0, 1, 32'h7F80_0000, 1);
        step(0, 1, 32'h8000_0000, 1);
        step(0, 1, 32'h0000_0001, 1);
        repeat (5) step(0, 0, 32'h0, 1);

        // Fill to DEPTH with the consumer stalled, then overrun once.
        for (int k = 0; k < 2; k++) begin
            repeat (4) step(1, 0, 32'h0, 0);
            for (int j = 0; j < 4; j++) step(0, 1, 32'h3F80_0000 + 32'(k * 4 + j), 0);
        end
        step(0, 1, 32'hDEAD_BEEF, 0);
        step(0, 0, 32'h0, 0);
        // Push and pop together while full: nothing dropped.
        step(0, 1, 32'h1234_5678, 1);
        step(0, 0, 32'h0, 0);
        repeat (10) step(0, 0, 32'h0, 1);

        // In-flight limit: credit drops at MAX_INF, recovers after one return.
        do_reset();
        repeat (4) step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        step(0, 1, 32'h4049_0FDB, 1);
        step(0, 0, 32'h0, 1);
        repeat (3) step(0, 1, $urandom, 1);
        repeat (4) step(0, 0, 32'h0, 1);

        // Reset with 5 stored entries and 2 in flight discards everything.
        repeat (4) step(1, 0, 32'h0, 0);
        repeat (4) step(0, 1, $urandom, 0);
        repeat (3) step(1, 0, 32'h0, 0);
        step(0, 1, $urandom, 0);
        check_outputs();
        do_reset();
        issue = 1'b0; alu_valid = 1'b0; out_ready = 1'b0;
        check_outputs();

        // Randomized traffic obeying the credit, with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            iss = ((q.size() + m_inflight) < DEPTH) && (m_inflight < MAX_INF) && ($urandom_range(1, 0) == 1);
            vld = (m_inflight > 0 && $urandom_range(2, 0) != 0) || ($urandom_range(19, 0) == 0);
            rv  = $urandom;
            case ($urandom_range(3, 0))
                0: rv[30:23] = 8'h00;
                1: rv[30:23] = 8'hFF;
                2: if ($urandom_range(1, 0) == 1) rv[22:0] = '0;
                default: ;
            endcase
            step(iss, vld, rv, (i % 64) < 40 ? ($urandom_range(3, 0) != 0) : 1'b0);
        end
        repeat (10) step(0, 0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_float_result_buffer
`default_nettype wire

// File: doc/float_result_buffer.md
Name: float_result_buffer

Overview:
Downstream stage of the float ALU. Captures every result the ALU emits on its valid pulse into a first-word-fall-through (FWFT) FIFO, and tags each entry with IEEE-754 class flags. Presents entries to a consumer over a valid/ready interface. The ALU has no backpressure, so the block also tracks in-flight operations and exposes a credit signal (can_issue); the issuer gates the ALU start signal with it, so no result is ever lost in normal operation.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
MAX_INFLIGHT, 4, upper bound on ALU operations in flight; sizes the in-flight counter.
DROP_W, 8, width of the saturating drop counter.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
issue  input  1  high in a cycle where the issuer asserts the ALU start signal (one operation launched)
alu_result  input  32  ALU result word
alu_valid  input  1  ALU valid_out; alu_result is captured in this cycle
can_issue  output  1  one more operation may be launched this cycle
out_data  output  32  head entry result word
out_flags  output  4  head entry flags {nan, inf, zero, subnormal}
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts the head entry
drop_count  output  DROP_W  results lost to overrun; saturates at all-ones
overrun  output  1  sticky; set on the first drop

Behaviour:
- Reset is synchronous and active-low, one clock, one reset; no asynchronous paths.
- Reset values: read/write pointers, count, inflight, drop_count all 0; overrun 0; out_valid 0; can_issue 1 in the first cycle after reset.
- Reset mid-operation discards all stored and in-flight bookkeeping. Results arriving after reset are still captured if space exists.
- Push: alu_valid=1 and (count<DEPTH or pop this cycle) writes {alu_result, flags} at wr_ptr, then wr_ptr increments.
- Pop: out_valid && out_ready advances rd_ptr.
- FWFT: out_data and out_flags reflect mem[rd_ptr] whenever out_valid=1. Write-to-visible latency is 1 cycle; a push into an empty FIFO raises out_valid on the next cycle.
- Simultaneous push and pop: legal at any count, including full. Count is unchanged.
- Pointers wrap modulo DEPTH.
- Overrun: alu_valid=1, count==DEPTH and no pop. The entry is discarded, drop_count increments (saturating) and overrun is set. overrun clears only on reset.
- Flags are computed from alu_result at write time and stored with the entry:
  - nan = exp==8'hFF and mant!=0
  - inf = exp==8'hFF and mant==0
  - zero = exp==0 and mant==0 (either sign)
  - subnormal = exp==0 and mant!=0
- inflight counter: +1 on issue, -1 on alu_valid; both together leaves it unchanged.
  - alu_valid while inflight==0 (spurious) keeps it at 0; the data is still pushed.
  - issue while inflight==MAX_INFLIGHT is an issuer error; the counter holds.
- can_issue = (count + inflight) < DEPTH and inflight < MAX_INFLIGHT, computed from registered state only (no combinational path from inputs).
- No FSM beyond the FIFO/credit counters; all outputs except can_issue and the FWFT data are registered.

Decomposition:
- Shared package float_pkg holds EXP_W=8, MANT_W=23, EXP_ALL_ONES constant, flag bit indices (FLAG_NAN=3 .. FLAG_SUB=0), and a classify function; the ALU reuses the same function.
- One natural sub-module: sync_fifo (parameterised width/depth, FWFT, full/empty/count outputs), instantiated with width 36.

Test Plan:
- Reset then three issues, then alu_valid with 0xC1940000 (-18.5), 0x41830000 (16.375), 0x41BE0000 (23.75) on consecutive cycles, out_ready=1 -> out_data in the same order, flags 0000 each, out_valid low after the third pop, inflight returns to 0.
- Push 0x7FC00000, 0x7F800000, 0x80000000, 0x00000001 -> out_flags 1000, 0100, 0010, 0001 respectively.
- out_ready=0, issue and return 8 results -> count=8, can_issue=0; a 9th alu_valid -> drop_count=1, overrun=1, the 9th value never appears on out_data.
- Full FIFO with push and pop in the same cycle -> no drop, count stays 8, next head correct.
- Issue 4 ops with no returns -> can_issue drops once inflight=4; the first alu_valid re-raises it the next cycle.
- rst_n low for one cycle with 5 entries and 2 in flight -> out_valid=0, drop_count=0, overrun=0, can_issue=1 the following cycle.
